// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU operation, strobes the ALU, captures C into ZHigh/ZLow, returns it.
// Optional build macro ALU_CHECK_EN adds an internal ALU reference model whose mismatches raise rsp_err.
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  output logic [DATA_W-1:0]   y_out,
  output logic [DATA_W-1:0]   bus_out,
  output logic                alu_add,
  output logic                alu_incpc,
  output logic                alu_and,
  output logic                alu_or,
  output logic                alu_branch,
  input  logic [2*DATA_W-1:0] alu_c,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_lo,
  output logic [DATA_W-1:0]   rsp_hi,
  output logic                rsp_err,
  output logic [CNT_W-1:0]    stat_ops,
  output logic [1:0]          dbg_state
);

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_INCPC  = 4'b1101;
  localparam logic [3:0] OP_BRANCH = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] z_low;
  logic [DATA_W-1:0] z_high;
  logic              accept;
  logic              req_legal;
  logic              strobe_on;
  logic              rsp_done;
  logic              check_fail;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_INCPC, OP_BRANCH: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  assign req_legal = op_is_legal(req_op);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // A producer holds valid and its payload until that edge; ready never waits on valid
  // combinationally except through clear. Requests are taken only in IDLE (one op in flight),
  // and the response payload stays frozen for as long as rsp_valid is high without rsp_ready.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = !clear;
        accept    = req_valid && !clear;
        if (req_valid) state_d = req_legal ? S_EXEC : S_RESP;
      end
      S_EXEC:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // The strobe is a pure decode of the latched op, so at most one can ever be high.
  always_comb begin
    strobe_on  = (state_q == S_EXEC) || (state_q == S_CAPTURE);
    alu_add    = 1'b0;
    alu_incpc  = 1'b0;
    alu_and    = 1'b0;
    alu_or     = 1'b0;
    alu_branch = 1'b0;
    if (strobe_on) begin
      case (op_q)
        OP_ADD:    alu_add    = 1'b1;
        OP_INCPC:  alu_incpc  = 1'b1;
        OP_AND:    alu_and    = 1'b1;
        OP_OR:     alu_or     = 1'b1;
        OP_BRANCH: alu_branch = 1'b1;
        default:   ;
      endcase
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_done  = rsp_valid && rsp_ready;
  assign rsp_lo    = z_low;
  assign rsp_hi    = z_high;
  assign dbg_state = state_q;

`ifdef ALU_CHECK_EN
  // Reference ALU: operands come from the held y_out/bus_out, upper half is always zero.
  logic [DATA_W-1:0] model_lo;

  always_comb begin
    model_lo = '0;
    case (op_q)
      OP_AND:    model_lo = y_out & bus_out;
      OP_OR:     model_lo = y_out | bus_out;
      OP_ADD:    model_lo = y_out + bus_out;
      OP_INCPC:  model_lo = bus_out + DATA_W'(1);
      OP_BRANCH: model_lo = y_out + bus_out + DATA_W'(1);
      default:   model_lo = '0;
    endcase
  end

  assign check_fail = (alu_c != {{DATA_W{1'b0}}, model_lo});
`else
  assign check_fail = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      y_out    <= '0;
      bus_out  <= '0;
      z_low    <= '0;
      z_high   <= '0;
      rsp_err  <= 1'b0;
      stat_ops <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= req_op;
        if (req_legal) begin
          y_out   <= req_a;
          bus_out <= req_b;
          rsp_err <= 1'b0;
        end else begin
          // Illegal ops skip the ALU entirely and report a zero result.
          z_low   <= '0;
          z_high  <= '0;
          rsp_err <= 1'b1;
        end
      end
      if (state_q == S_CAPTURE) begin
        z_low  <= alu_c[DATA_W-1:0];
        z_high <= alu_c[2*DATA_W-1:DATA_W];
        if (check_fail) rsp_err <= 1'b1;
      end
      if (rsp_done) stat_ops <= stat_ops + CNT_W'(1);
    end
  end

  a_strobe_onehot: assert property (@(posedge clock) disable iff (clear)
    $onehot0({alu_add, alu_incpc, alu_and, alu_or, alu_branch}));

  a_rsp_stable: assert property (@(posedge clock) disable iff (clear)
    (rsp_valid && !rsp_ready) |=> ($stable(rsp_lo) && $stable(rsp_hi) && $stable(rsp_err)));

  a_ready_only_idle: assert property (@(posedge clock) disable iff (clear)
    req_ready |-> (state_q == S_IDLE));

endmodule
